// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for regfile_mp and its read-port sub-module.
// Default geometry is 96 entries x 65 bits with 3 read and 2 write ports.
package regfile_pkg;

   localparam int REGFILE_NREGS_DEF  = 96;
   localparam int REGFILE_WIDTH_DEF  = 65;
   localparam int REGFILE_NREAD_DEF  = 3;
   localparam int REGFILE_NWRITE_DEF = 2;

   // Per-port error vector at default geometry: reads in low bits, writes in high bits.
   typedef logic [REGFILE_NREAD_DEF+REGFILE_NWRITE_DEF-1:0] regfile_err_t;

   function automatic int regfile_aw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One synchronous read port: range check, valid gating, optional write bypass (REGFILE_BYPASS_EN), 1-cycle output register.
// Latency 1 cycle; no backpressure; a disabled port holds its last value.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int NREGS  = REGFILE_NREGS_DEF,
   parameter int WIDTH  = REGFILE_WIDTH_DEF,
   parameter int NWRITE = REGFILE_NWRITE_DEF,
   parameter int AW     = regfile_aw(REGFILE_NREGS_DEF)
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic [AW-1:0]           addr,
   input  logic [NREGS-1:0]        valid,
   input  logic [WIDTH-1:0]        word,
   input  logic [NWRITE-1:0]       w_en,
   input  logic [NWRITE*AW-1:0]    w_addr,
   input  logic [NWRITE*WIDTH-1:0] w_data,
   output logic [WIDTH-1:0]        data,
   output logic                    oor
);

   localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

   logic             in_range;
   logic [WIDTH-1:0] nxt;

   always_comb begin
      in_range = ({1'b0, addr} < LIMIT);
      nxt      = '0;
      if (in_range && valid[addr]) nxt = word;
`ifdef REGFILE_BYPASS_EN
      // Ascending scan so the highest-indexed matching writer is forwarded.
      for (int j = 0; j < NWRITE; j++) begin
         if (in_range && w_en[j] && (w_addr[j*AW +: AW] == addr)) nxt = w_data[j*WIDTH +: WIDTH];
      end
`endif
   end

`ifndef REGFILE_BYPASS_EN
   logic unused_w;
   assign unused_w = ^{w_en, w_addr, w_data};
`endif

   assign oor = en && !in_range;

   always_ff @(posedge clock) begin
      if (!reset_n)  data <= '0;
      else if (en)   data <= nxt;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD synchronous reads (1-cycle latency), NWRITE writes, per-entry valid, sticky range errors.
// No backpressure. Define REGFILE_BYPASS_EN for write-first same-cycle reads; read-first otherwise.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int NREGS  = REGFILE_NREGS_DEF,
   parameter int WIDTH  = REGFILE_WIDTH_DEF,
   parameter int NREAD  = REGFILE_NREAD_DEF,
   parameter int NWRITE = REGFILE_NWRITE_DEF,
   parameter int AW     = regfile_aw(NREGS)
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [NREAD-1:0]        r_en,
   input  logic [NREAD*AW-1:0]     r_addr,
   output logic [NREAD*WIDTH-1:0]  r_data,
   input  logic [NWRITE-1:0]       w_en,
   input  logic [NWRITE*AW-1:0]    w_addr,
   input  logic [NWRITE*WIDTH-1:0] w_data,
   output logic                    err,
   output logic [NREAD+NWRITE-1:0] err_port
);

   localparam logic [AW:0] LIMIT = (AW+1)'(NREGS);

   logic [WIDTH-1:0]  mem [NREGS];
   logic [NREGS-1:0]  valid;
   logic [NREAD-1:0]  r_oor;
   logic [NWRITE-1:0] w_ok;
   logic [NWRITE-1:0] w_oor;

   always_comb begin
      w_ok  = '0;
      w_oor = '0;
      for (int j = 0; j < NWRITE; j++) begin
         w_ok[j]  = w_en[j] &&  ({1'b0, w_addr[j*AW +: AW]} < LIMIT);
         w_oor[j] = w_en[j] && !({1'b0, w_addr[j*AW +: AW]} < LIMIT);
      end
   end

   // Array is never cleared; valid gating hides stale contents after reset.
   // Ascending loop: the highest-indexed writer's update lands last and wins.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         for (int j = 0; j < NWRITE; j++) begin
            if (w_ok[j]) mem[w_addr[j*AW +: AW]] <= w_data[j*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid    <= '0;
         err_port <= '0;
         err      <= 1'b0;
      end else begin
         for (int j = 0; j < NWRITE; j++) begin
            if (w_ok[j]) valid[w_addr[j*AW +: AW]] <= 1'b1;
         end
         err_port <= err_port | {w_oor, r_oor};
         err      <= err | (|{w_oor, r_oor});
      end
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] a;
      assign a = r_addr[i*AW +: AW];

      regfile_rd_port #(
         .NREGS  (NREGS),
         .WIDTH  (WIDTH),
         .NWRITE (NWRITE),
         .AW     (AW)
      ) u_rd (
         .clock   (clock),
         .reset_n (reset_n),
         .en      (r_en[i]),
         .addr    (a),
         .valid   (valid),
         .word    (mem[a]),
         .w_en    (w_en),
         .w_addr  (w_addr),
         .w_data  (w_data),
         .data    (r_data[i*WIDTH +: WIDTH]),
         .oor     (r_oor[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default geometry (96x65, 3R/2W).
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int NREGS  = 96;
   localparam int WIDTH  = 65;
   localparam int NREAD  = 3;
   localparam int NWRITE = 2;
   localparam int AW     = 7;

   localparam logic [WIDTH-1:0] BIG = 65'h1_DEAD_BEEF_CAFE_F00D;

   logic                    clock = 1'b0;
   logic                    reset_n = 1'b0;
   logic [NREAD-1:0]        r_en = '0;
   logic [NREAD*AW-1:0]     r_addr = '0;
   logic [NREAD*WIDTH-1:0]  r_data;
   logic [NWRITE-1:0]       w_en = '0;
   logic [NWRITE*AW-1:0]    w_addr = '0;
   logic [NWRITE*WIDTH-1:0] w_data = '0;
   logic                    err;
   regfile_err_t            err_port;

   logic [WIDTH-1:0] model [NREGS];
   int n_tests = 0;
   int n_fail  = 0;

   regfile_mp dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .r_en     (r_en),
      .r_addr   (r_addr),
      .r_data   (r_data),
      .w_en     (w_en),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .err      (err),
      .err_port (err_port)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_rd(input int p, input int a);
      r_en[p] = 1'b1;
      r_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input int a, input logic [WIDTH-1:0] d);
      w_en[p] = 1'b1;
      w_addr[p*AW +: AW] = AW'(a);
      w_data[p*WIDTH +: WIDTH] = d;
   endtask

   // Advance one edge, sample 1ns later, then drop all enables for the next vector.
   task automatic tick();
      @(posedge clock);
      #1;
      r_en = '0;
      w_en = '0;
   endtask

   function automatic logic [WIDTH-1:0] rd(input int p);
      return r_data[p*WIDTH +: WIDTH];
   endfunction

   initial begin
      for (int i = 0; i < NREGS; i++) model[i] = '0;

      // Reset state
      tick();
      tick();
      for (int p = 0; p < NREAD; p++) chk($sformatf("rst_rdata%0d", p), rd(p), '0);
      chk("rst_err", WIDTH'(err), '0);
      chk("rst_err_port", WIDTH'(err_port), '0);
      reset_n = 1'b1;

      // Never-written entries read as zero
      set_rd(0, 0); set_rd(1, 47); set_rd(2, 95);
      tick();
      chk("empty_r0", rd(0), '0);
      chk("empty_r1", rd(1), '0);
      chk("empty_r2", rd(2), '0);
      chk("empty_err", WIDTH'(err), '0);

      // Basic write then read, then hold with r_en low
      set_wr(0, 10, BIG); model[10] = BIG;
      tick();
      set_rd(1, 10);
      tick();
      chk("wr10_r1", rd(1), BIG);
      r_addr[1*AW +: AW] = AW'(47);
      tick();
      chk("hold_r1", rd(1), BIG);

      // Write collision: higher port wins
      set_wr(0, 20, 65'h5); set_wr(1, 20, 65'hA); model[20] = 65'hA;
      tick();
      set_rd(0, 20);
      tick();
      chk("collide20", rd(0), 65'hA);

      // Same-cycle read/write to a valid entry
      set_wr(0, 30, 65'h3);
      tick();
      set_wr(0, 30, 65'h7); set_rd(0, 30); model[30] = 65'h7;
      tick();
`ifdef REGFILE_BYPASS_EN
      chk("same_cyc30", rd(0), 65'h7);
`else
      chk("same_cyc30", rd(0), 65'h3);
`endif
      set_rd(0, 30);
      tick();
      chk("next_cyc30", rd(0), 65'h7);

      // Same-cycle read of an invalid entry, and of a colliding pair
      set_wr(0, 40, 65'h11); set_rd(0, 40); model[40] = 65'h11;
      set_wr(1, 50, 65'h2);  set_rd(1, 50); model[50] = 65'h2;
      tick();
`ifdef REGFILE_BYPASS_EN
      chk("byp_inv40", rd(0), 65'h11);
`else
      chk("byp_inv40", rd(0), '0);
`endif
      set_wr(0, 60, 65'h1); set_wr(1, 60, 65'h2); set_rd(2, 60); model[60] = 65'h2;
      tick();
`ifdef REGFILE_BYPASS_EN
      chk("byp_col60", rd(2), 65'h2);
`else
      chk("byp_col60", rd(2), '0);
`endif

      // Top in-range entry
      set_wr(1, 95, 65'h55); model[95] = 65'h55;
      tick();
      set_rd(0, 95); set_rd(1, 40);
      tick();
      chk("top95", rd(0), 65'h55);
      chk("rd40", rd(1), 65'h11);
      chk("no_err_yet", WIDTH'(err), '0);

      // Out-of-range accesses
      set_rd(2, 10);
      tick();
      chk("pre_oor_r2", rd(2), BIG);
      set_wr(0, 100, 65'hFF); set_rd(2, 120);
      tick();
      chk("oor_r2", rd(2), '0);
      chk("oor_err", WIDTH'(err), 65'h1);
      chk("oor_err_port", WIDTH'(err_port), 65'b01100);
      tick();
      tick();
      chk("sticky_err", WIDTH'(err), 65'h1);
      chk("sticky_err_port", WIDTH'(err_port), 65'b01100);

      for (int i = 0; i < NREGS; i++) begin
         set_rd(0, i);
         tick();
         chk($sformatf("reread%0d", i), rd(0), model[i]);
      end

      // Reset drops same-cycle writes and reads, clears valid and errors
      set_wr(0, 5, 65'h9);
      tick();
      reset_n = 1'b0;
      set_wr(0, 6, 65'h4); set_rd(1, 5);
      tick();
      for (int p = 0; p < NREAD; p++) chk($sformatf("rst2_rdata%0d", p), rd(p), '0);
      chk("rst2_err", WIDTH'(err), '0);
      chk("rst2_err_port", WIDTH'(err_port), '0);
      reset_n = 1'b1;

      // First edge after reset accepts both reads and writes
      set_rd(0, 5); set_rd(1, 6); set_wr(1, 7, 65'h33);
      tick();
      chk("post_rst5", rd(0), '0);
      chk("post_rst6", rd(1), '0);
      chk("post_rst_err", WIDTH'(err), '0);
      set_rd(2, 7); set_rd(0, 95);
      tick();
      chk("post_rst7", rd(2), 65'h33);
      chk("post_rst95", rd(0), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
